// File: rtl/regfile_pkg.sv
// Shared constants and source encoding for the register-file write-back arbiter.
package regfile_pkg;

    localparam int unsigned REGFILE_NREGS = 16;
    localparam int unsigned REGFILE_AW    = 4;
    localparam int unsigned REGFILE_DW    = 32;

    typedef enum logic {
        WB_EX = 1'b0,
        WB_LD = 1'b1
    } wb_src_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between the execute/load writeback sources, decode and the register file.
interface regfile_wb_arbiter_if
    import regfile_pkg::*;
#(
    parameter int unsigned NREGS = REGFILE_NREGS,
    parameter int unsigned AW    = REGFILE_AW,
    parameter int unsigned DW    = REGFILE_DW
) ();

    logic             ex_valid;
    logic [AW-1:0]    ex_rd;
    logic [DW-1:0]    ex_data;
    logic             ex_ready;
    logic             ld_valid;
    logic [AW-1:0]    ld_rd;
    logic [DW-1:0]    ld_data;
    logic             ld_ready;
    logic             rf_we;
    logic [AW-1:0]    rf_rd;
    logic [DW-1:0]    rf_wdata;
    logic             issue_valid;
    logic [AW-1:0]    issue_rd;
    logic [NREGS-1:0] busy;

    modport slave (
        input  ex_valid, ex_rd, ex_data, ld_valid, ld_rd, ld_data, issue_valid, issue_rd,
        output ex_ready, ld_ready, rf_we, rf_rd, rf_wdata, busy
    );

    modport master (
        output ex_valid, ex_rd, ex_data, ld_valid, ld_rd, ld_data, issue_valid, issue_rd,
        input  ex_ready, ld_ready, rf_we, rf_rd, rf_wdata, busy
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer moves to the loser only on a contended grant.
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    wb_src_t ptr_q, ptr_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= WB_EX;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        grant = req;
        if (req == 2'b11) begin
            grant = (ptr_q == WB_EX) ? 2'b01 : 2'b10;
            if (advance) begin
                ptr_d = (ptr_q == WB_EX) ? WB_LD : WB_EX;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between execute and load writeback.
// Define REGFILE_WB_SCOREBOARD_EN to build the per-register busy scoreboard.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned NREGS = REGFILE_NREGS,
    parameter int unsigned AW    = REGFILE_AW,
    parameter int unsigned DW    = REGFILE_DW
) (
    input logic                 clk,
    input logic                 reset,
    regfile_wb_arbiter_if.slave wb
);

    logic [1:0]    req;
    logic [1:0]    grant;
    logic          xfer;
    logic [AW-1:0] win_rd;
    logic [DW-1:0] win_data;

    logic          rf_we_q;
    logic [AW-1:0] rf_rd_q;
    logic [DW-1:0] rf_wdata_q;

    assign req = {wb.ld_valid, wb.ex_valid};

    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .advance (wb.ex_valid & wb.ld_valid),
        .grant   (grant)
    );

    assign wb.ex_ready = grant[0];
    assign wb.ld_ready = grant[1];

    always_comb begin
        xfer     = |grant;
        win_rd   = grant[1] ? wb.ld_rd   : wb.ex_rd;
        win_data = grant[1] ? wb.ld_data : wb.ex_data;
    end

    // Register 0 is hardwired zero: the request is consumed but never written.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_we_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_wdata_q <= '0;
        end else begin
            rf_we_q <= xfer && (win_rd != '0);
            if (xfer) begin
                rf_rd_q    <= win_rd;
                rf_wdata_q <= win_data;
            end
        end
    end

    assign wb.rf_we    = rf_we_q;
    assign wb.rf_rd    = rf_rd_q;
    assign wb.rf_wdata = rf_wdata_q;

`ifdef REGFILE_WB_SCOREBOARD_EN
    logic [NREGS-1:0] busy_q, busy_d;

    // A fresh issue outranks the clear from a retiring write to the same register.
    always_comb begin
        busy_d = busy_q;
        if (rf_we_q) begin
            busy_d[rf_rd_q] = 1'b0;
        end
        if (wb.issue_valid && (wb.issue_rd != '0)) begin
            busy_d[wb.issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign wb.busy = busy_q;
`else
    logic unused_issue;
    assign unused_issue = ^{wb.issue_valid, wb.issue_rd};
    assign wb.busy      = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, reset corner case, random vs model.
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    localparam int unsigned NREGS = REGFILE_NREGS;
    localparam int unsigned AW    = REGFILE_AW;
    localparam int unsigned DW    = REGFILE_DW;

`ifdef REGFILE_WB_SCOREBOARD_EN
    localparam logic SB = 1'b1;
`else
    localparam logic SB = 1'b0;
`endif

    logic clk    = 1'b0;
    logic reset  = 1'b0;
    logic rf_clr = 1'b1;

    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.NREGS(NREGS), .AW(AW), .DW(DW)) wb ();

    regfile_wb_arbiter #(.NREGS(NREGS), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .wb    (wb)
    );

    // Stand-in for the registers block.
    logic [DW-1:0] regs [NREGS];
    always @(posedge clk) begin
        if (rf_clr) begin
            for (int k = 0; k < NREGS; k++) regs[k] <= '0;
        end else if (wb.rf_we) begin
            regs[wb.rf_rd] <= wb.rf_wdata;
        end
    end

    // Requesters must hold valid/rd/data stable until granted.
    logic          p_ex_wait = 1'b0, p_ld_wait = 1'b0;
    logic [AW-1:0] p_ex_rd, p_ld_rd;
    logic [DW-1:0] p_ex_data, p_ld_data;
    always @(posedge clk) begin
        if (reset && p_ex_wait)
            assert (wb.ex_valid && wb.ex_rd == p_ex_rd && wb.ex_data == p_ex_data)
            else $error("ex requester changed before transfer");
        if (reset && p_ld_wait)
            assert (wb.ld_valid && wb.ld_rd == p_ld_rd && wb.ld_data == p_ld_data)
            else $error("ld requester changed before transfer");
        p_ex_wait <= reset && wb.ex_valid && !wb.ex_ready;
        p_ld_wait <= reset && wb.ld_valid && !wb.ld_ready;
        p_ex_rd   <= wb.ex_rd;
        p_ex_data <= wb.ex_data;
        p_ld_rd   <= wb.ld_rd;
        p_ld_data <= wb.ld_data;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: whose turn it is under contention, the pending write, busy set.
    int               m_turn;
    logic             m_we;
    logic [AW-1:0]    m_rd;
    logic [DW-1:0]    m_wd;
    logic [NREGS-1:0] m_busy;
    logic [DW-1:0]    m_regs [NREGS];

    task automatic model_reset();
        m_turn = 0;
        m_we   = 1'b0;
        m_rd   = '0;
        m_wd   = '0;
        m_busy = '0;
    endtask

    function automatic logic exp_ex_ready();
        return wb.ex_valid && (!wb.ld_valid || m_turn == 0);
    endfunction

    function automatic logic exp_ld_ready();
        return wb.ld_valid && (!wb.ex_valid || m_turn == 1);
    endfunction

    // Advance the model over one rising edge using the inputs present before it.
    task automatic model_edge(output int win);
        if (m_we) begin
            m_regs[m_rd] = m_wd;
            m_busy[m_rd] = 1'b0;
        end
        if (SB && wb.issue_valid && wb.issue_rd != 0) m_busy[wb.issue_rd] = 1'b1;
        win = -1;
        if (wb.ex_valid && wb.ld_valid) begin
            win    = m_turn;
            m_turn = 1 - m_turn;
        end else if (wb.ex_valid) begin
            win = 0;
        end else if (wb.ld_valid) begin
            win = 1;
        end
        m_we = 1'b0;
        if (win >= 0) begin
            m_rd = (win == 1) ? wb.ld_rd : wb.ex_rd;
            m_wd = (win == 1) ? wb.ld_data : wb.ex_data;
            m_we = (m_rd != 0);
        end
    endtask

    task automatic step(output int win);
        @(negedge clk);
        chk("ex_ready", 32'(wb.ex_ready), 32'(exp_ex_ready()));
        chk("ld_ready", 32'(wb.ld_ready), 32'(exp_ld_ready()));
        @(posedge clk);
        model_edge(win);
        #1;
        chk("rf_we", 32'(wb.rf_we), 32'(m_we));
        chk("rf_rd", 32'(wb.rf_rd), 32'(m_rd));
        chk("rf_wdata", wb.rf_wdata, m_wd);
        chk("busy", 32'(wb.busy), 32'(m_busy));
    endtask

    typedef struct {
        logic ev; logic [AW-1:0] erd; logic [DW-1:0] ed;
        logic lv; logic [AW-1:0] lrd; logic [DW-1:0] ld;
        logic iv; logic [AW-1:0] ird;
        logic xer; logic xlr; logic xwe; logic [AW-1:0] xrd; logic [DW-1:0] xwd; logic xb7;
    } vec_t;

    vec_t vecs [13];

    initial begin
        int w;
        int n;
        vecs[0]  = '{1'b1, 4'd5, 32'h5,  1'b0, 4'd0, 32'h0, 1'b0, 4'd0,
                     1'b1, 1'b0, 1'b1, 4'd5, 32'h5, 1'b0};
        vecs[1]  = '{1'b0, 4'd0, 32'h0,  1'b0, 4'd0, 32'h0, 1'b0, 4'd0,
                     1'b0, 1'b0, 1'b0, 4'd5, 32'h5, 1'b0};
        vecs[2]  = '{1'b1, 4'd3, 32'h33, 1'b1, 4'd4, 32'h44, 1'b0, 4'd0,
                     1'b1, 1'b0, 1'b1, 4'd3, 32'h33, 1'b0};
        vecs[3]  = '{1'b0, 4'd0, 32'h0,  1'b1, 4'd4, 32'h44, 1'b0, 4'd0,
                     1'b0, 1'b1, 1'b1, 4'd4, 32'h44, 1'b0};
        vecs[4]  = '{1'b1, 4'd3, 32'h33, 1'b1, 4'd4, 32'h44, 1'b0, 4'd0,
                     1'b0, 1'b1, 1'b1, 4'd4, 32'h44, 1'b0};
        vecs[5]  = '{1'b1, 4'd3, 32'h33, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0,
                     1'b1, 1'b0, 1'b1, 4'd3, 32'h33, 1'b0};
        vecs[6]  = '{1'b0, 4'd0, 32'h0,  1'b1, 4'd0, 32'h99999999, 1'b0, 4'd0,
                     1'b0, 1'b1, 1'b0, 4'd0, 32'h99999999, 1'b0};
        vecs[7]  = '{1'b0, 4'd0, 32'h0,  1'b0, 4'd0, 32'h0, 1'b1, 4'd7,
                     1'b0, 1'b0, 1'b0, 4'd0, 32'h99999999, SB};
        vecs[8]  = '{1'b1, 4'd7, 32'h77, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0,
                     1'b1, 1'b0, 1'b1, 4'd7, 32'h77, SB};
        vecs[9]  = '{1'b0, 4'd0, 32'h0,  1'b0, 4'd0, 32'h0, 1'b1, 4'd7,
                     1'b0, 1'b0, 1'b0, 4'd7, 32'h77, SB};
        vecs[10] = '{1'b1, 4'd7, 32'h78, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0,
                     1'b1, 1'b0, 1'b1, 4'd7, 32'h78, SB};
        vecs[11] = '{1'b0, 4'd0, 32'h0,  1'b0, 4'd0, 32'h0, 1'b0, 4'd0,
                     1'b0, 1'b0, 1'b0, 4'd7, 32'h78, 1'b0};
        vecs[12] = '{1'b0, 4'd0, 32'h0,  1'b0, 4'd0, 32'h0, 1'b1, 4'd0,
                     1'b0, 1'b0, 1'b0, 4'd7, 32'h78, 1'b0};

        wb.ex_valid = 1'b0; wb.ex_rd = '0; wb.ex_data = '0;
        wb.ld_valid = 1'b0; wb.ld_rd = '0; wb.ld_data = '0;
        wb.issue_valid = 1'b0; wb.issue_rd = '0;
        model_reset();
        for (int k = 0; k < NREGS; k++) m_regs[k] = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset rf_we", 32'(wb.rf_we), 32'h0);
        chk("reset rf_rd", 32'(wb.rf_rd), 32'h0);
        chk("reset rf_wdata", wb.rf_wdata, 32'h0);
        chk("reset busy", 32'(wb.busy), 32'h0);
        @(negedge clk);
        reset  = 1'b1;
        rf_clr = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) begin
            wb.ex_valid = vecs[i].ev; wb.ex_rd = vecs[i].erd; wb.ex_data = vecs[i].ed;
            wb.ld_valid = vecs[i].lv; wb.ld_rd = vecs[i].lrd; wb.ld_data = vecs[i].ld;
            wb.issue_valid = vecs[i].iv; wb.issue_rd = vecs[i].ird;
            @(negedge clk);
            chk($sformatf("vec%0d ex_ready", i), 32'(wb.ex_ready), 32'(vecs[i].xer));
            chk($sformatf("vec%0d ld_ready", i), 32'(wb.ld_ready), 32'(vecs[i].xlr));
            @(posedge clk);
            model_edge(w);
            #1;
            chk($sformatf("vec%0d rf_we", i), 32'(wb.rf_we), 32'(vecs[i].xwe));
            chk($sformatf("vec%0d rf_rd", i), 32'(wb.rf_rd), 32'(vecs[i].xrd));
            chk($sformatf("vec%0d rf_wdata", i), wb.rf_wdata, vecs[i].xwd);
            chk($sformatf("vec%0d busy7", i), 32'(wb.busy[7]), 32'(vecs[i].xb7));
            chk($sformatf("vec%0d busy", i), 32'(wb.busy), 32'(m_busy));
        end
        chk("regfile r5", regs[5], 32'h5);
        chk("regfile r3", regs[3], 32'h33);
        chk("regfile r4", regs[4], 32'h44);
        chk("regfile r7", regs[7], 32'h78);
        chk("regfile r0", regs[0], 32'h0);

        // Reset in the middle of a pending write, with the pointer turned to ld.
        wb.ex_valid = 1'b1; wb.ex_rd = 4'd1; wb.ex_data = 32'h11;
        wb.ld_valid = 1'b1; wb.ld_rd = 4'd2; wb.ld_data = 32'h22;
        wb.issue_valid = 1'b1; wb.issue_rd = 4'd9;
        @(posedge clk);
        model_edge(w);
        #1;
        chk("pre-reset rf_we", 32'(wb.rf_we), 32'h1);
        chk("pre-reset busy9", 32'(wb.busy[9]), 32'(SB));
        wb.ex_valid = 1'b0; wb.ld_valid = 1'b0; wb.issue_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("async rf_we", 32'(wb.rf_we), 32'h0);
        chk("async rf_rd", 32'(wb.rf_rd), 32'h0);
        chk("async rf_wdata", wb.rf_wdata, 32'h0);
        chk("async busy", 32'(wb.busy), 32'h0);
        model_reset();
        wb.ex_valid = 1'b1; wb.ld_valid = 1'b1;
        #1;
        chk("reset ptr ex_ready", 32'(wb.ex_ready), 32'h1);
        chk("reset ptr ld_ready", 32'(wb.ld_ready), 32'h0);
        @(posedge clk);
        #1;
        chk("no xfer in reset", 32'(wb.rf_we), 32'h0);
        wb.ex_valid = 1'b0; wb.ld_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int c = 0; c < 400; c++) begin
            if (!wb.ex_valid && $urandom_range(1, 0) == 1) begin
                wb.ex_valid = 1'b1;
                wb.ex_rd    = 4'($urandom_range(15, 0));
                wb.ex_data  = $urandom;
            end
            if (!wb.ld_valid && $urandom_range(1, 0) == 1) begin
                wb.ld_valid = 1'b1;
                wb.ld_rd    = 4'($urandom_range(15, 0));
                wb.ld_data  = $urandom;
            end
            wb.issue_valid = 1'($urandom_range(1, 0));
            wb.issue_rd    = 4'($urandom_range(15, 0));
            step(w);
            if (w == 0) wb.ex_valid = 1'b0;
            if (w == 1) wb.ld_valid = 1'b0;
        end

        wb.issue_valid = 1'b0;
        n = 0;
        while ((wb.ex_valid || wb.ld_valid) && n < 10) begin
            step(w);
            if (w == 0) wb.ex_valid = 1'b0;
            if (w == 1) wb.ld_valid = 1'b0;
            n++;
        end
        chk("drain pending", 32'(wb.ex_valid | wb.ld_valid), 32'h0);
        wb.ex_valid = 1'b0; wb.ld_valid = 1'b0;
        step(w);
        step(w);
        for (int k = 0; k < NREGS; k++) chk($sformatf("final r%0d", k), regs[k], m_regs[k]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and scoreboard for the CPU's 16 x 32-bit register file. It shares the register file's single write port between the execute-stage writeback and the load-unit writeback using a fair round-robin valid/ready handshake. It registers the winning write onto the register file's `we`/`rd`/`write_data` inputs. Optionally, it tracks per-register pending writes so decode can stall on read-after-write hazards. It sits between the execute/memory stages and the `registers` block.

## Interface
- `NREGS`, 16, number of architectural registers
- `AW`, 4, register address width (log2 NREGS)
- `DW`, 32, data width
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low reset
- `ex_valid` in 1: execute writeback request
- `ex_rd` in AW: execute destination register
- `ex_data` in DW: execute result
- `ex_ready` out 1: execute request granted this cycle
- `ld_valid` in 1: load writeback request
- `ld_rd` in AW: load destination register
- `ld_data` in DW: load data
- `ld_ready` out 1: load request granted this cycle
- `rf_we` out 1: register file write enable
- `rf_rd` out AW: register file write address
- `rf_wdata` out DW: register file write data
- `issue_valid` in 1: an instruction writing `issue_rd` was issued
- `issue_rd` in AW: destination of the issued instruction
- `busy` out NREGS: bit i set means a write to register i is pending

## Operation
- **Transfer:** occurs on a requester when `valid && ready` at a rising edge.
- **Ready generation:** `ready` is combinational from the valids and the priority pointer.
  - With one valid, it is granted.
  - With both valid, the requester whose turn it is is granted; the other sees `ready`=0.
  - With none valid, both readies are 0.
- **Requester rules:** once `valid` is raised, it, `rd` and `data` are held stable until the transfer. The bench asserts this.
- **Priority pointer:** 1 bit, 0 = execute first.
  - It updates only on a contended transfer, pointing to the loser.
  - An uncontended transfer leaves it unchanged.
  - Neither requester waits more than one transfer under contention.
- **Write to register 0:** the request is accepted normally, but `rf_we` is not asserted. Register 0 is hardwired zero.
- **Output registers:** on a transfer, the winner's rd/data load into `rf_rd`/`rf_wdata` and `rf_we` sets for exactly one cycle. Otherwise `rf_we`=0, and `rf_rd`/`rf_wdata` hold their values.
- **Scoreboard set:** `issue_valid` with a nonzero `issue_rd` sets `busy[issue_rd]` at the next edge.
- **Scoreboard clear:** a cycle with `rf_we`=1 clears `busy[rf_rd]` at its closing edge, i.e. when the register file captures the data.
- **Set and clear on the same register, same edge:** set wins, because a new pending write exists.
- **`busy[0]`:** always 0.

## Timing
- **Reset values (on `reset` low, asynchronous, immediate):**
  - `rf_we`=0, `rf_rd`=0, `rf_wdata`=0
  - `busy`=0
  - pointer=0
  - `ex_ready`/`ld_ready` follow the valids, but no transfer occurs while `reset` is low.
- **Reset mid-operation:** any registered, unwritten writeback is discarded.
- **Latency:**
  - Transfer at edge N.
  - `rf_we` is high during cycle N..N+1.
  - The register file holds the data after edge N+1.
  - `busy` clears at edge N+1.
- **Throughput:** one writeback per cycle. Back-to-back transfers produce back-to-back `rf_we` pulses.
- **Issue to busy:** one cycle (`issue_valid` at edge M is visible in `busy` after M).

## Configuration
- Macro `REGFILE_WB_SCOREBOARD_EN`.
- **Defined:** the busy-bit scoreboard is built as described above.
- **Undefined:**
  - `busy` is tied to all zeros.
  - `issue_valid`/`issue_rd` are ignored, but the ports remain.
  - The arbitration and write path are unchanged.

## Structure
- **Package `regfile_pkg`:**
  - constants `REGFILE_NREGS`=16, `REGFILE_AW`=4, `REGFILE_DW`=32
  - typedef `wb_src_t` (`WB_EX`=0, `WB_LD`=1) for the pointer and grant encoding
- **Sub-module `rr_arbiter2`:** a 2-way round-robin arbiter holding the pointer.
  - Inputs: req[1:0] and an advance strobe.
  - Outputs: a one-hot grant.
- The top level holds the output registers and the scoreboard.

## Test plan
- **Reset:** assert `reset`=0 mid-cycle with `rf_we`=1 -> `rf_we`, `rf_rd`, `rf_wdata` and `busy` are 0 immediately, and the pointer is 0.
- **Single execute write:** `ex_valid`=1, rd=5, data=0x00000005 -> `ex_ready`=1. The next cycle has `rf_we`=1, `rf_rd`=5, `rf_wdata`=5, and the register file reads 5 afterwards.
- **Contention:** both valid, ex rd=3/0x33, ld rd=4/0x44, held for 2 cycles.
  - Expect ex granted first, then ld.
  - Expect `rf_we` pulses with rd 3 then rd 4 on consecutive cycles.
  - Repeat the contention: ld is now granted first.
- **Register 0:** `ld_valid`=1, rd=0, data=0x99999999 -> `ld_ready`=1, `rf_we` stays 0, and register 0 reads 0.
- **Scoreboard (macro defined):**
  - `issue_valid`, rd=7 -> `busy[7]`=1 next cycle.
  - An ex write to rd 7 clears `busy[7]` at the edge after the `rf_we` cycle.
  - An issue to rd 7 on that same edge -> `busy[7]` stays 1.
- **Scoreboard (macro undefined):** the same stimulus -> `busy` stays 0 throughout.
